// File: rtl/jtag_dr_bridge_pkg.sv
// Shared types and constants for the JTAG user-DR to request-bus bridge.
package jtag_dr_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  // DR field offsets (data field starts right after the address)
  localparam int DR_WE_BIT   = 0;
  localparam int DR_ADDR_LSB = 1;

  // TAP input positions in the synchroniser vector
  localparam int TAP_TCK = 0;
  localparam int TAP_TDI = 1;
  localparam int TAP_SEL = 2;
  localparam int TAP_CAP = 3;
  localparam int TAP_SHF = 4;
  localparam int TAP_UPD = 5;
  localparam int TAP_RST = 6;
  localparam int TAP_NUM = 7;

  function automatic int dr_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/gc_sync_ffs.sv
// Plain flip-flop chain synchroniser for one asynchronous bit.
module gc_sync_ffs #(
  parameter int g_stages = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic data_i,
  output logic synced_o
);

  logic [g_stages-1:0] sr_q;

  // shift the raw bit through the chain, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sr_q <= '0;
    else          sr_q <= {sr_q[g_stages-2:0], data_i};
  end

  assign synced_o = sr_q[g_stages-1];

endmodule

// File: rtl/jtag_dr_bridge.sv
// JTAG user data register bridged to a valid/ready request bus with a
// read-response return path. Optional overrun flag: JTAG_DR_BRIDGE_OVR_EN.
module jtag_dr_bridge
  import jtag_dr_bridge_pkg::*;
#(
  parameter int g_addr_width  = 4,
  parameter int g_data_width  = 32,
  parameter int g_sync_stages = 2
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    tck_i,
  input  logic                    tdi_i,
  input  logic                    sel_i,
  input  logic                    capture_i,
  input  logic                    shift_i,
  input  logic                    update_i,
  input  logic                    tap_reset_i,
  output logic                    tdo_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic                    req_we_o,
  output logic [g_addr_width-1:0] req_addr_o,
  output logic [g_data_width-1:0] req_data_o,
  input  logic                    rsp_valid_i,
  input  logic [g_data_width-1:0] rsp_data_i,
  output logic                    busy_o,
  output logic                    ovr_o
);

  localparam int W        = dr_width(g_addr_width, g_data_width);
  localparam int DATA_LSB = DR_ADDR_LSB + g_addr_width;

  logic [TAP_NUM-1:0] tap_raw, tap_s;
  logic               tck_prev_q, upd_prev_q, tck_rise_q, upd_rise_q;
  logic [W-1:0]       dr_q, dr_d;
  state_e             state_q, state_d;
  logic               we_q;
  logic [g_addr_width-1:0] addr_q, last_addr_q;
  logic [g_data_width-1:0] data_q, rd_data_q;
  logic               busy, cap_fire, shf_fire, upd_hit, upd_accept;

  assign tap_raw = {tap_reset_i, update_i, shift_i, capture_i, sel_i, tdi_i, tck_i};

  for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_sync
    gc_sync_ffs #(.g_stages(g_sync_stages)) u_sync (
      .clk_i    (clk_sys_i),
      .rst_n_i  (rst_n_i),
      .data_i   (tap_raw[gi]),
      .synced_o (tap_s[gi])
    );
  end

  // registered rising-edge strobes; prev flops reset low with the chain so
  // nothing fires right after reset
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      tck_prev_q <= 1'b0;
      upd_prev_q <= 1'b0;
      tck_rise_q <= 1'b0;
      upd_rise_q <= 1'b0;
    end else begin
      tck_prev_q <= tap_s[TAP_TCK];
      upd_prev_q <= tap_s[TAP_UPD];
      tck_rise_q <= tap_s[TAP_TCK] & ~tck_prev_q;
      upd_rise_q <= tap_s[TAP_UPD] & ~upd_prev_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cap_fire   = tck_rise_q & tap_s[TAP_SEL] & tap_s[TAP_CAP];
  assign shf_fire   = tck_rise_q & tap_s[TAP_SEL] & tap_s[TAP_SHF] & ~tap_s[TAP_CAP];
  assign upd_hit    = upd_rise_q & tap_s[TAP_SEL];
  assign upd_accept = upd_hit & ~busy;

  // DR next value: TAP reset wins, then capture, then shift
  always_comb begin
    dr_d = dr_q;
    if (tap_s[TAP_RST])  dr_d = '0;
    else if (cap_fire)   dr_d = {rd_data_q, last_addr_q, busy};
    else if (shf_fire)   dr_d = {tap_s[TAP_TDI], dr_q[W-1:1]};
  end

  // transaction FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (upd_accept)  state_d = S_REQ;
      S_REQ:      if (req_ready_i) state_d = we_q ? S_IDLE : S_WAIT_RSP;
      S_WAIT_RSP: if (rsp_valid_i) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // state, DR and payload registers; payload latched so it holds during REQ
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      dr_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      last_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      if (upd_accept) begin
        we_q        <= dr_q[DR_WE_BIT];
        addr_q      <= dr_q[DATA_LSB-1:DR_ADDR_LSB];
        data_q      <= dr_q[W-1:DATA_LSB];
        last_addr_q <= dr_q[DATA_LSB-1:DR_ADDR_LSB];
      end
      if (state_q == S_WAIT_RSP && rsp_valid_i) rd_data_q <= rsp_data_i;
    end
  end

`ifdef JTAG_DR_BRIDGE_OVR_EN
  logic ovr_q;
  // sticky overrun: set by a dropped update, cleared by an idle capture
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i)                ovr_q <= 1'b0;
    else if (upd_hit && busy)    ovr_q <= 1'b1;
    else if (cap_fire && !busy)  ovr_q <= 1'b0;
  end
  assign ovr_o = ovr_q;
`else
  assign ovr_o = 1'b0;
`endif

  assign tdo_o       = dr_q[0];
  assign req_valid_o = (state_q == S_REQ);
  assign req_we_o    = we_q;
  assign req_addr_o  = addr_q;
  assign req_data_o  = data_q;
  assign busy_o      = busy;

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge (addr 4, data 32, 2 sync stages).
module tb_jtag_dr_bridge;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int W  = 1 + AW + DW;

`ifdef JTAG_DR_BRIDGE_OVR_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic          gclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tck = 0, tdi = 0, sel = 0, cap = 0, shf = 0, upd = 0, trst = 0;
  logic          tdo, req_valid, req_ready = 0, req_we, busy, ovr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid = 0;
  logic [DW-1:0] rsp_data = '0;

  int n_chk = 0, n_pass = 0;

  always #5 gclk = ~gclk;

  jtag_dr_bridge #(.g_addr_width(AW), .g_data_width(DW), .g_sync_stages(2)) dut (
    .clk_sys_i(gclk), .rst_n_i(rst_n),
    .tck_i(tck), .tdi_i(tdi), .sel_i(sel), .capture_i(cap), .shift_i(shf),
    .update_i(upd), .tap_reset_i(trst), .tdo_o(tdo),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
    .req_addr_o(req_addr), .req_data_o(req_data),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
    .busy_o(busy), .ovr_o(ovr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // one TCK period = 16 system clocks
  task automatic tck_pulse();
    tck = 1'b1; repeat (8) @(negedge gclk);
    tck = 1'b0; repeat (8) @(negedge gclk);
  endtask

  // shift val in LSB first, collecting the previous DR contents from tdo
  task automatic shift_dr(input logic s, input logic [W-1:0] val, output logic [W-1:0] out);
    sel = s; shf = 1'b1;
    for (int i = 0; i < W; i++) begin
      tdi = val[i];
      out[i] = tdo;
      tck_pulse();
    end
    shf = 1'b0; sel = 1'b0;
  endtask

  task automatic capture_dr();
    sel = 1'b1; cap = 1'b1; tck_pulse(); cap = 1'b0; sel = 1'b0;
  endtask

  // raise update and count clocks until req_valid (0 if it never comes)
  task automatic update_dr(input logic s, output int lat);
    sel = s; upd = 1'b1; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge gclk); #1;
      if (req_valid) begin lat = n; break; end
    end
    @(negedge gclk); upd = 1'b0;
    repeat (4) @(negedge gclk); sel = 1'b0;
  endtask

  task automatic no_req(input string tag);
    int seen = 0;
    repeat (12) begin @(negedge gclk); if (req_valid) seen++; end
    chk(tag, seen, 0);
  endtask

  logic [W-1:0] v, o;
  int lat;

  initial begin
    repeat (3) @(negedge gclk);
    chk("rst_valid", req_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_tdo",   tdo, 0);
    chk("rst_ovr",   ovr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge gclk);
    chk("post_rst_no_req", req_valid, 0);

    // write with ready held off 5 clocks
    v = (37'hDEADBEEF << 5) | (37'h3 << 1) | 37'h1;
    shift_dr(1'b1, v, o);
    chk("first_shift_out_zero", o, 0);
    sel = 1'b1; upd = 1'b1; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge gclk); #1;
      if (req_valid) begin lat = n; break; end
    end
    chk("wr_latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      chk("wr_valid_held", req_valid, 1);
      chk("wr_we",   req_we, 1);
      chk("wr_addr", req_addr, 4'h3);
      chk("wr_data", req_data, 32'hDEADBEEF);
      if (k == 2) begin upd = 1'b0; sel = 1'b0; end
      if (k < 4) begin @(posedge gclk); #1; end
    end
    req_ready = 1'b1;
    @(posedge gclk); #1;
    req_ready = 1'b0;
    chk("wr_done_valid", req_valid, 0);
    chk("wr_done_busy",  busy, 0);

    // read of address 5
    shift_dr(1'b1, 37'h0A, o);
    update_dr(1'b1, lat);
    chk("rd_req_seen", lat != 0, 1);
    chk("rd_we",   req_we, 0);
    chk("rd_addr", req_addr, 4'h5);
    @(negedge gclk); req_ready = 1'b1;
    @(negedge gclk); req_ready = 1'b0;
    chk("rd_wait_busy",  busy, 1);
    chk("rd_wait_valid", req_valid, 0);

    // capture while waiting: busy bit set, last addr 5, old read data 0
    capture_dr();
    shift_dr(1'b1, '0, o);
    chk("busy_capture_bit0", o[0], 1);
    chk("busy_capture_dr", o, 37'h0B);

    // overrun: second update while busy is dropped
    update_dr(1'b1, lat);
    chk("ovr_no_second_req", lat, 0);
    chk("ovr_flag", ovr, OVR_EXP);
    chk("ovr_still_busy", busy, 1);

    @(negedge gclk); rsp_data = 32'h12345678; rsp_valid = 1'b1;
    @(negedge gclk); rsp_valid = 1'b0; rsp_data = '0;
    chk("rsp_idle", busy, 0);

    // response ignored once idle
    @(negedge gclk); rsp_data = 32'hCAFEF00D; rsp_valid = 1'b1;
    @(negedge gclk); rsp_valid = 1'b0;

    capture_dr();
    chk("ovr_cleared", ovr, 0);
    shift_dr(1'b1, '0, o);
    chk("rd_capture_dr", o, (37'h12345678 << 5) | 37'h0A);

    // sel low: DR untouched, no request
    v = 37'h1_2345_6789;
    shift_dr(1'b1, v, o);
    shift_dr(1'b0, 37'h0_FFFF_FFFF, o);
    update_dr(1'b0, lat);
    chk("nosel_no_req", lat, 0);
    shift_dr(1'b1, '0, o);
    chk("nosel_dr_kept", o, v);

    // tap reset clears DR
    shift_dr(1'b1, 37'h1F_0F0F_0F0F, o);
    trst = 1'b1; repeat (6) @(negedge gclk); trst = 1'b0;
    repeat (4) @(negedge gclk);
    shift_dr(1'b1, '0, o);
    chk("tap_reset_dr", o, 0);
    chk("tap_reset_fsm", busy, 0);

    // reset in REQ abandons the transaction
    shift_dr(1'b1, (37'h55AA55AA << 5) | (37'h9 << 1) | 37'h1, o);
    update_dr(1'b1, lat);
    chk("rstreq_entered", req_valid, 1);
    @(posedge gclk); #1 rst_n = 1'b0;
    @(posedge gclk); #1 rst_n = 1'b1;
    chk("rstreq_valid", req_valid, 0);
    chk("rstreq_busy",  busy, 0);
    chk("rstreq_tdo",   tdo, 0);
    chk("rstreq_ovr",   ovr, 0);
    no_req("rstreq_no_retry");
    capture_dr();
    shift_dr(1'b1, '0, o);
    chk("rstreq_capture_zero", o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
